// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, free-running oversample tick generator and
// 8N1 deframer. Define UART_RX_PARITY_EN to add an even-parity bit (8E1 framing).
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } state_e;

  logic              rx_meta_q, rx_s_q;
  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic              s_tick;

  state_e            state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic              par_bad_q, par_bad_d;

  // Sync flops come out of reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Tick generator runs unconditionally; the FSM's s counter absorbs the phase.
  assign s_tick = (cnt_q == DVSR_W'(DVSR - 1));
  assign cnt_d  = s_tick ? '0 : cnt_q + DVSR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // NOTE: every comb output gets a default before the case, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            par_bad_d = (^b_q) ^ rx_s_q;
            s_d       = '0;
            state_d   = STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            if (rx_s_q) begin
              state_d = IDLE;
              if (par_bad_q) begin
                perr_d = 1'b1;
              end else begin
                done_d = 1'b1;
                dout_d = b_q;
              end
            end else begin
              // A low stop bit is reported once; BRK waits out a held-low line.
              ferr_d  = 1'b1;
              state_d = BRK;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
  logic unused_perr;
  assign unused_perr  = perr_q ^ par_bad_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DVSR=4 (64 clk per bit). Counts output pulses on the
// falling edge and compares them against hand-computed expectations.
module tb_uart_rx;

  localparam int DBIT     = 8;
  localparam int DVSR     = 4;
  localparam int BIT_CLKS = DVSR * 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  int n_tests = 0;
  int n_fail  = 0;

  int done_cnt    = 0;
  int ferr_cnt    = 0;
  int perr_cnt    = 0;
  int overlap_cnt = 0;
  logic [7:0] byte_log[$];

  uart_rx #(
    .DBIT   (DBIT),
    .SB_TICK(16),
    .DVSR   (DVSR),
    .DVSR_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      byte_log.push_back(dout);
    end
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (int'(rx_done_tick) + int'(frame_err) + int'(parity_err) > 1) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_lvl, input logic par_lvl);
    send_bit(1'b0);
    for (int i = 0; i < DBIT; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_lvl);
`else
    if (par_lvl) wait_clks(0);
`endif
    send_bit(stop_lvl);
  endtask

  function automatic logic [31:0] logged(input int idx);
    if (idx < byte_log.size()) return {24'd0, byte_log[idx]};
    return 32'hDEAD;
  endfunction

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(5);
    check("reset_dout", dout, 0);
    check("reset_done", rx_done_tick, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_perr", parity_err, 0);
    reset = 1'b0;

    wait_clks(2000);
    check("idle_done_cnt", done_cnt, 0);
    check("idle_ferr_cnt", ferr_cnt, 0);
    check("idle_perr_cnt", perr_cnt, 0);

    send_frame(8'hA5, 1'b1, 1'b0);
    wait_clks(10);
    check("a5_done_cnt", done_cnt, 1);
    check("a5_byte", logged(0), 32'hA5);
    check("a5_ferr_cnt", ferr_cnt, 0);
    wait_clks(200);
    check("a5_dout_held", dout, 32'hA5);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_clks(10);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_first", logged(1), 32'h00);
    check("b2b_second", logged(2), 32'hFF);

    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(300);
    check("glitch_done_cnt", done_cnt, 3);
    check("glitch_ferr_cnt", ferr_cnt, 0);

    send_frame(8'h3C, 1'b0, 1'b0);
    wait_clks(500);
    check("brk_ferr_cnt", ferr_cnt, 1);
    check("brk_done_cnt", done_cnt, 3);
    check("brk_dout_kept", dout, 32'hFF);
    rx = 1'b1;
    wait_clks(100);
    check("brk_no_new_pulse", done_cnt + ferr_cnt, 4);
    send_frame(8'h96, 1'b1, 1'b0);
    wait_clks(10);
    check("recover_done_cnt", done_cnt, 4);
    check("recover_byte", logged(3), 32'h96);

    // Abort a frame partway through DATA with reset, line returned to idle.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(3);
    check("midreset_dout", dout, 0);
    reset = 1'b0;
    wait_clks(BIT_CLKS * 12);
    check("midreset_no_pulse", done_cnt + ferr_cnt + perr_cnt, 5);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_clks(10);
    check("post_reset_done_cnt", done_cnt, 5);
    check("post_reset_dout", dout, 32'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b0);
    wait_clks(10);
    check("par_ok_done_cnt", done_cnt, 6);
    check("par_ok_dout", dout, 32'h81);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_clks(10);
    check("par_bad_perr_cnt", perr_cnt, 1);
    check("par_bad_done_cnt", done_cnt, 6);
    check("par_bad_dout_kept", dout, 32'h81);
`else
    check("noparity_perr_cnt", perr_cnt, 0);
`endif

    check("one_hot_pulses", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
